async_com_peer: RTL



---
 rtl/async_com_pkg.sv | 28 ++
 rtl/async_com_shifter.sv | 57 +++++
 rtl/async_com_peer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/async_com_pkg.sv
// ============================================================================
// Module  : async_com_pkg
// Purpose : Shared state encoding and bus constants for the async handshake link.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package async_com_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TX_REQ   = 3'd1,
    S_TX_SHIFT = 3'd2,
    S_TX_END   = 3'd3,
    S_RX_SHIFT = 3'd4,
    S_RX_WAIT  = 3'd5
  } comState_t;

  localparam logic c_BUS_RELEASE = 1'bz;

  // The peer owns devB only while it is asking for or using the bus.
  function automatic logic ownsLine(input comState_t s);
    return (s == S_TX_REQ) || (s == S_TX_SHIFT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/async_com_shifter.sv
// ============================================================================
// Module  : async_com_shifter
// Purpose : WIDTH-bit indexed shift/capture register with saturating bit counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module async_com_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic             capture,
  input  logic             load,
  input  logic [WIDTH-1:0] parIn,
  input  logic             serIn,
  output logic [WIDTH-1:0] word,
  output logic             bitOut,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      if (load)
        r_shift <= parIn;
      else if (capture)
        r_shift[r_cnt] <= serIn;
      // Counter saturates at the terminal index instead of wrapping.
      if (clear)
        r_cnt <= '0;
      else if (step && !last)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  assign last   = (r_cnt == CW'(WIDTH - 1));
  assign bitOut = r_shift[r_cnt];

  // Word as it will look once the bit currently on serIn is captured.
  always_comb begin
    word        = r_shift;
    word[r_cnt] = serIn;
  end

endmodule

`default_nettype wire

// File: rtl/async_com_peer.sv
// ============================================================================
// Module  : async_com_peer
// Purpose : Peer endpoint of the single-wire async handshake link (devA/devB).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module async_com_peer
  import async_com_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             devA,
  output logic             devB,
  inout  tri               dataBus,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             abort
);

  comState_t        r_state;
  logic             r_pending;
  logic [WIDTH-1:0] r_txHold;
  logic [WIDTH-1:0] r_rxData;
  logic             r_rxValid;
  logic             r_abort;

  logic             w_grant;
  logic             w_rxStart;
  logic             w_rxStep;
  logic             w_txBit;
  logic             w_txLast;
  logic             w_rxLast;
  logic [WIDTH-1:0] w_rxWord;
  logic [WIDTH-1:0] w_txWordUnused;
  logic             w_rxBitUnused;

  assign w_grant   = (r_state == S_TX_REQ) && devA;
  assign w_rxStart = (r_state == S_IDLE) && devA;
  assign w_rxStep  = (r_state == S_RX_SHIFT) && devA;

  // Reloaded from the holding register on every grant so an aborted word restarts at bit 0.
  async_com_shifter #(.WIDTH(WIDTH)) u_txShifter (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_grant),
    .step    (r_state == S_TX_SHIFT),
    .capture (1'b0),
    .load    (w_grant),
    .parIn   (r_txHold),
    .serIn   (1'b0),
    .word    (w_txWordUnused),
    .bitOut  (w_txBit),
    .last    (w_txLast)
  );

  async_com_shifter #(.WIDTH(WIDTH)) u_rxShifter (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_rxStart),
    .step    (w_rxStep),
    .capture (w_rxStep),
    .load    (1'b0),
    .parIn   ({WIDTH{1'b0}}),
    .serIn   (dataBus),
    .word    (w_rxWord),
    .bitOut  (w_rxBitUnused),
    .last    (w_rxLast)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_txHold  <= '0;
      r_rxData  <= '0;
      r_rxValid <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_rxValid <= 1'b0;
      r_abort   <= 1'b0;
      if (tx_load && !r_pending) begin
        r_txHold  <= tx_data;
        r_pending <= 1'b1;
      end
      case (r_state)
        // Receive has priority; a pending word simply retries after the partner is done.
        S_IDLE: begin
          if (devA)
            r_state <= S_RX_SHIFT;
          else if (r_pending)
            r_state <= S_TX_REQ;
        end
        S_TX_REQ: begin
          if (devA)
            r_state <= S_TX_SHIFT;
        end
        S_TX_SHIFT: begin
          if (!devA) begin
            r_abort <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_txLast) begin
            r_pending <= 1'b0;
            r_state   <= S_TX_END;
          end
        end
        S_TX_END: begin
          if (!devA)
            r_state <= S_IDLE;
        end
        S_RX_SHIFT: begin
          if (!devA) begin
            r_abort <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_rxLast) begin
            r_rxData  <= w_rxWord;
            r_rxValid <= 1'b1;
            r_state   <= S_RX_WAIT;
          end
        end
        S_RX_WAIT: begin
          if (!devA)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign devB     = ownsLine(r_state);
  assign dataBus  = (r_state == S_TX_SHIFT) ? w_txBit : c_BUS_RELEASE;
  assign tx_ready = !r_pending;
  assign rx_data  = r_rxData;
  assign rx_valid = r_rxValid;
  assign abort    = r_abort;

endmodule

`default_nettype wire
